// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the datapath width, the branch condition encodings and the
// 2-bit saturating counter used by the branch history table.
package pipeline;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        BrEq  = 3'b000,
        BrNe  = 3'b001,
        BrLt  = 3'b100,
        BrGe  = 3'b101,
        BrLtu = 3'b110,
        BrGeu = 3'b111
    } branch_op_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BhtInit = 2'b01;

    // Moves the counter one step toward the resolved direction, holding at 00 and 11.
    function automatic bht_cnt_t bht_next(bht_cnt_t cnt, logic taken);
        bht_cnt_t nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != 2'b11) nxt = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator; the two reserved funct3 encodings are flagged
// as illegal and always evaluate as not taken.
module branch_cmp
    import pipeline::*;
#(
    parameter int unsigned XLEN = pipeline::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond,
    output logic            illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (branch_op_e'(funct3))
            BrEq:    cond = (rs1 == rs2);
            BrNe:    cond = (rs1 != rs2);
            BrLt:    cond = ($signed(rs1) < $signed(rs2));
            BrGe:    cond = ($signed(rs1) >= $signed(rs2));
            BrLtu:   cond = (rs1 < rs2);
            BrGeu:   cond = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: one-cycle lookup from a table of 2-bit counters, plus a
// registered resolve stage that reports the outcome, any redirect and running statistics.
module branch_predict_unit
    import pipeline::*;
#(
    parameter int unsigned XLEN        = pipeline::XLEN,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic [XLEN-1:0]  f_pc,
    output logic             p_valid,
    output logic             p_taken,
    input  logic             r_valid,
    input  logic             r_jump,
    input  logic             r_branch,
    input  logic [2:0]       r_funct3,
    input  logic [XLEN-1:0]  r_pc,
    input  logic [XLEN-1:0]  r_target,
    input  logic [XLEN-1:0]  r_rs1_data,
    input  logic [XLEN-1:0]  r_rs2_data,
    input  logic             r_pred_taken,
    output logic             je,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal,
    output logic [CNT_W-1:0] n_branch,
    output logic [CNT_W-1:0] n_mispredict
);

    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

    logic [IdxW-1:0] f_idx;
    logic [IdxW-1:0] r_idx;

    bht_cnt_t bht_q [BHT_ENTRIES];

    logic             p_valid_q, p_taken_q;
    logic             je_q, mispredict_q, illegal_q;
    logic [XLEN-1:0]  redirect_q;
    logic [CNT_W-1:0] n_branch_q, n_mispredict_q;

    logic             cond, cmp_illegal;
    logic             is_br, resolve, taken;
    logic             je_d, mispredict_d, illegal_d;
    logic [XLEN-1:0]  redirect_d;
    logic             upd_en;
    bht_cnt_t         upd_val;
    logic [CNT_W-1:0] n_branch_d, n_mispredict_d;

    // Word-aligned instructions: bits [1:0] and everything above the index are not hashed.
    logic unused_pc;
    assign unused_pc = ^{f_pc[XLEN-1:IdxW+2], f_pc[1:0]};

    assign f_idx = f_pc[IdxW+1:2];
    assign r_idx = r_pc[IdxW+1:2];

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .funct3  (r_funct3),
        .rs1     (r_rs1_data),
        .rs2     (r_rs2_data),
        .cond    (cond),
        .illegal (cmp_illegal)
    );

    always_comb begin
        is_br          = r_branch & ~r_jump;
        resolve        = r_valid & (r_jump | r_branch);
        taken          = r_jump | (is_br & cond);
        je_d           = resolve & taken;
        mispredict_d   = resolve & (taken != r_pred_taken);
        illegal_d      = r_valid & is_br & cmp_illegal;
        redirect_d     = '0;
        if (mispredict_d) begin
            redirect_d = taken ? r_target : r_pc + XLEN'(4);
        end
        upd_en         = r_valid & is_br & ~cmp_illegal;
        upd_val        = bht_next(bht_q[r_idx], cond);
        n_branch_d     = n_branch_q;
        n_mispredict_d = n_mispredict_q;
        if (resolve && n_branch_q != '1) begin
            n_branch_d = n_branch_q + CNT_W'(1);
        end
        if (mispredict_d && n_mispredict_q != '1) begin
            n_mispredict_d = n_mispredict_q + CNT_W'(1);
        end
    end

    // Lookup reads bht_q before this edge's update lands, so a same-index
    // lookup and update in one cycle returns the old counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= BhtInit;
            end
        end else if (upd_en) begin
            bht_q[r_idx] <= upd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid_q      <= 1'b0;
            p_taken_q      <= 1'b0;
            je_q           <= 1'b0;
            mispredict_q   <= 1'b0;
            illegal_q      <= 1'b0;
            redirect_q     <= '0;
            n_branch_q     <= '0;
            n_mispredict_q <= '0;
        end else begin
            p_valid_q      <= f_valid;
            p_taken_q      <= f_valid & bht_q[f_idx][1];
            je_q           <= je_d;
            mispredict_q   <= mispredict_d;
            illegal_q      <= illegal_d;
            redirect_q     <= redirect_d;
            n_branch_q     <= n_branch_d;
            n_mispredict_q <= n_mispredict_d;
        end
    end

    assign p_valid      = p_valid_q;
    assign p_taken      = p_taken_q;
    assign je           = je_q;
    assign mispredict   = mispredict_q;
    assign illegal      = illegal_q;
    assign redirect_pc  = redirect_q;
    assign n_branch     = n_branch_q;
    assign n_mispredict = n_mispredict_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: hand-computed vectors for lookup, resolve,
// counter saturation, aliasing, illegal encodings, wraparound and mid-stream reset.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        p_valid, p_taken;
    logic        r_valid, r_jump, r_branch;
    logic [2:0]  r_funct3;
    logic [31:0] r_pc, r_target, r_rs1_data, r_rs2_data;
    logic        r_pred_taken;
    logic        je, mispredict, illegal;
    logic [31:0] redirect_pc;
    logic [31:0] n_branch, n_mispredict;

    int total = 0;
    int bad   = 0;
    int exp_nb = 0;
    int exp_nm = 0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .XLEN        (32),
        .BHT_ENTRIES (64),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .f_valid      (f_valid),
        .f_pc         (f_pc),
        .p_valid      (p_valid),
        .p_taken      (p_taken),
        .r_valid      (r_valid),
        .r_jump       (r_jump),
        .r_branch     (r_branch),
        .r_funct3     (r_funct3),
        .r_pc         (r_pc),
        .r_target     (r_target),
        .r_rs1_data   (r_rs1_data),
        .r_rs2_data   (r_rs2_data),
        .r_pred_taken (r_pred_taken),
        .je           (je),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .illegal      (illegal),
        .n_branch     (n_branch),
        .n_mispredict (n_mispredict)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".p_valid"}, 64'(p_valid), 64'd0);
        check({tag, ".p_taken"}, 64'(p_taken), 64'd0);
        check({tag, ".je"}, 64'(je), 64'd0);
        check({tag, ".mispredict"}, 64'(mispredict), 64'd0);
        check({tag, ".illegal"}, 64'(illegal), 64'd0);
        check({tag, ".redirect"}, 64'(redirect_pc), 64'd0);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_taken);
        f_valid = 1'b1;
        f_pc    = pc;
        tick();
        f_valid = 1'b0;
        check({tag, ".p_valid"}, 64'(p_valid), 64'd1);
        check({tag, ".p_taken"}, 64'(p_taken), 64'(exp_taken));
    endtask

    task automatic resolve(input string tag, input logic jmp, input logic br,
                           input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic pred,
                           input logic e_je, input logic e_mp, input logic [31:0] e_red,
                           input logic e_ill);
        r_valid      = 1'b1;
        r_jump       = jmp;
        r_branch     = br;
        r_funct3     = f3;
        r_pc         = pc;
        r_target     = tgt;
        r_rs1_data   = rs1;
        r_rs2_data   = rs2;
        r_pred_taken = pred;
        tick();
        r_valid = 1'b0;
        if (jmp || br) exp_nb++;
        if (e_mp) exp_nm++;
        check({tag, ".je"}, 64'(je), 64'(e_je));
        check({tag, ".mispredict"}, 64'(mispredict), 64'(e_mp));
        check({tag, ".redirect"}, 64'(redirect_pc), 64'(e_red));
        check({tag, ".illegal"}, 64'(illegal), 64'(e_ill));
    endtask

    initial begin
        rst = 1'b1; f_valid = 1'b0; f_pc = '0;
        r_valid = 1'b0; r_jump = 1'b0; r_branch = 1'b0; r_funct3 = '0;
        r_pc = '0; r_target = '0; r_rs1_data = '0; r_rs2_data = '0; r_pred_taken = 1'b0;
        tick();
        tick();
        check_quiet("rst");
        check("rst.n_branch", 64'(n_branch), 64'd0);
        check("rst.n_mispredict", 64'(n_mispredict), 64'd0);

        // Requests sampled during reset must not leak out afterwards.
        f_valid = 1'b1; f_pc = 32'h100;
        r_valid = 1'b1; r_jump = 1'b1; r_target = 32'h2000; r_pred_taken = 1'b0;
        tick();
        rst = 1'b0; f_valid = 1'b0; r_valid = 1'b0; r_jump = 1'b0;
        tick();
        check_quiet("rst_drop");
        check("rst_drop.n_branch", 64'(n_branch), 64'd0);

        lookup("lk_init", 32'h100, 1'b0);
        tick();
        check_quiet("idle");

        // Train 0x100 up to saturation, then back down.
        resolve("beq1", 0, 1, 3'b000, 32'h100, 32'h180, 5, 5, 0, 1, 1, 32'h180, 0);
        resolve("beq2", 0, 1, 3'b000, 32'h100, 32'h180, 5, 5, 0, 1, 1, 32'h180, 0);
        lookup("lk_beq2", 32'h100, 1'b1);
        resolve("beq3", 0, 1, 3'b000, 32'h100, 32'h180, 5, 5, 1, 1, 0, 32'h0, 0);
        resolve("beq4", 0, 1, 3'b000, 32'h100, 32'h180, 5, 5, 1, 1, 0, 32'h0, 0);
        lookup("lk_alias", 32'h1100, 1'b1);
        resolve("beq_nt1", 0, 1, 3'b000, 32'h100, 32'h180, 5, 6, 1, 0, 1, 32'h104, 0);
        lookup("lk_sat_hi", 32'h100, 1'b1);
        resolve("beq_nt2", 0, 1, 3'b000, 32'h100, 32'h180, 5, 6, 1, 0, 1, 32'h104, 0);
        lookup("lk_down", 32'h100, 1'b0);

        resolve("blt", 0, 1, 3'b100, 32'h204, 32'h300, 32'hFFFF_FFFF, 1, 0, 1, 1, 32'h300, 0);
        resolve("bltu", 0, 1, 3'b110, 32'h204, 32'h300, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0, 0);
        resolve("bne", 0, 1, 3'b001, 32'h204, 32'h300, 5, 6, 1, 1, 0, 32'h0, 0);
        resolve("bge", 0, 1, 3'b101, 32'h204, 32'h300, 32'hFFFF_FFFF, 1, 1, 0, 1, 32'h208, 0);
        resolve("bgeu", 0, 1, 3'b111, 32'h204, 32'h300, 32'hFFFF_FFFF, 1, 0, 1, 1, 32'h300, 0);

        resolve("jal", 1, 0, 3'b000, 32'h408, 32'h2000, 0, 0, 0, 1, 1, 32'h2000, 0);
        lookup("lk_jal", 32'h408, 1'b0);
        resolve("jal_br", 1, 1, 3'b000, 32'h408, 32'h2000, 7, 7, 1, 1, 0, 32'h0, 0);
        lookup("lk_jal_br", 32'h408, 1'b0);

        resolve("beq50c", 0, 1, 3'b000, 32'h50C, 32'h600, 1, 1, 0, 1, 1, 32'h600, 0);
        resolve("ill010", 0, 1, 3'b010, 32'h50C, 32'h600, 1, 1, 0, 0, 0, 32'h0, 1);
        lookup("lk_ill010", 32'h50C, 1'b1);
        resolve("ill011", 0, 1, 3'b011, 32'h50C, 32'h600, 1, 1, 1, 0, 1, 32'h510, 1);
        lookup("lk_ill011", 32'h50C, 1'b1);

        resolve("wrap", 0, 1, 3'b000, 32'hFFFF_FFFC, 32'h40, 1, 2, 1, 0, 1, 32'h0, 0);
        resolve("nobr", 0, 0, 3'b010, 32'h714, 32'h40, 3, 3, 1, 0, 0, 32'h0, 0);

        // Same-index lookup and update in one cycle.
        f_valid = 1'b1;
        f_pc    = 32'h610;
        resolve("same", 0, 1, 3'b000, 32'h610, 32'h700, 3, 3, 0, 1, 1, 32'h700, 0);
        f_valid = 1'b0;
        check("same.p_valid", 64'(p_valid), 64'd1);
        check("same.p_taken", 64'(p_taken), 64'd0);
        lookup("lk_same", 32'h610, 1'b1);

        resolve("beq714", 0, 1, 3'b000, 32'h714, 32'h800, 9, 9, 1, 1, 0, 32'h0, 0);
        lookup("lk_714", 32'h714, 1'b1);
        check("stat.n_branch", 64'(n_branch), 64'(exp_nb));
        check("stat.n_mispredict", 64'(n_mispredict), 64'(exp_nm));
        check("stat.n_branch_val", 64'(n_branch), 64'd19);

        // Mid-stream reset with live requests.
        rst = 1'b1;
        f_valid = 1'b1; f_pc = 32'h714;
        r_valid = 1'b1; r_jump = 1'b1; r_branch = 1'b0; r_pc = 32'h408;
        r_target = 32'h2000; r_pred_taken = 1'b0;
        tick();
        check_quiet("mid_rst");
        check("mid_rst.n_branch", 64'(n_branch), 64'd0);
        check("mid_rst.n_mispredict", 64'(n_mispredict), 64'd0);
        rst = 1'b0; f_valid = 1'b0; r_valid = 1'b0; r_jump = 1'b0;
        tick();
        check_quiet("post_rst");
        lookup("lk_rst_714", 32'h714, 1'b0);
        lookup("lk_rst_50c", 32'h50C, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, default pipeline::XLEN, datapath width.
REQ-002 Parameter BHT_ENTRIES, default 64, number of 2-bit counters; power of two, >= 2.
REQ-003 Parameter CNT_W, default 32, width of statistics counters.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 f_valid  input  1  fetch lookup request.
REQ-007 f_pc  input  XLEN  fetch PC.
REQ-008 p_valid  output  1  prediction valid, one cycle after f_valid.
REQ-009 p_taken  output  1  predicted taken.
REQ-010 r_valid  input  1  resolve request.
REQ-011 r_jump, r_branch  input  1 each  instruction is jump / conditional branch.
REQ-012 r_funct3  input  3  branch condition.
REQ-013 r_pc, r_target  input  XLEN each  instruction PC, computed taken target.
REQ-014 r_rs1_data, r_rs2_data  input  XLEN each  operands.
REQ-015 r_pred_taken  input  1  prediction issued for this instruction.
REQ-016 je  output  1  registered: resolved taken.
REQ-017 mispredict  output  1  registered: redirect required.
REQ-018 redirect_pc  output  XLEN  registered: correct next PC.
REQ-019 illegal  output  1  registered: r_branch with unsupported funct3.
REQ-020 n_branch, n_mispredict  output  CNT_W each  statistics.

Function
REQ-021 Index = pc[$clog2(BHT_ENTRIES)+1:2] for lookup and update.
REQ-022 Lookup: f_valid at cycle N -> p_valid=1, p_taken=counter[idx][1] at N+1; p_valid=0 otherwise.
REQ-023 Conditions: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; 010/011 -> not taken, illegal=1.
REQ-024 Taken = r_jump | (r_branch & cond); r_jump overrides r_branch.
REQ-025 Resolve latency one cycle: r_valid at N -> je, mispredict, redirect_pc, illegal valid at N+1; all 0 in cycles with no prior r_valid.
REQ-026 mispredict = taken != r_pred_taken, only when r_jump|r_branch; r_valid with neither -> all outputs 0.
REQ-027 redirect_pc = r_target if taken else r_pc+4 (modulo 2^XLEN); 0 when mispredict=0.
REQ-028 Counter update only on r_valid & r_branch & ~r_jump & ~illegal: taken -> +1 saturating at 11, else -1 saturating at 00; jumps never update.
REQ-029 Lookup and update on same index, same cycle: lookup returns pre-update value.
REQ-030 n_branch increments per r_valid with r_jump|r_branch; n_mispredict per mispredict; both saturate at all-ones.

Reset
REQ-031 rst at an edge: all counters -> 01 (weakly not-taken); p_valid, p_taken, je, mispredict, illegal, redirect_pc, n_branch, n_mispredict -> 0.
REQ-032 Requests sampled in a reset cycle are discarded; no output pulse follows reset deassertion.

Structure
REQ-033 pipeline package holds branch_op_e enum (funct3 encodings) and bht_cnt_t 2-bit counter type.
REQ-034 Sub-module branch_cmp: combinational condition evaluator (funct3, rs1, rs2 -> cond, illegal).

Verification
REQ-035 Reset, f_pc=0x100 -> p_taken=0 next cycle.
REQ-036 Two BEQ at pc 0x100, rs1=rs2=5, pred 0 -> cycle1 mispredict=1, redirect_pc=r_target; lookup 0x100 then p_taken=1; third resolve -> counter 11, fourth holds 11.
REQ-037 BLT rs1=0xFFFFFFFF, rs2=1 -> je=1; BLTU same operands -> je=0.
REQ-038 JAL pred 0, target 0x2000 -> mispredict=1, redirect 0x2000, counter unchanged.
REQ-039 funct3=010 branch -> illegal=1, je=0, counter unchanged; r_pc=0xFFFFFFFC not taken, pred 1 -> redirect_pc=0.
REQ-040 Same-index lookup+update in one cycle -> p_taken old value; rst mid-stream clears outputs and counters to 01.
